duty_button_ctrl: RTL and testbench

Upstream control stage for the PWM generator on the TinyFPGA BX. Takes the raw user push button (asynchronous, bouncy), synchronises and debounces it, and turns each qualified press into one duty-cycle step (20→30→…→100→20). The new duty value is handed to the PWM only at a PWM period boundary, so a period is never cut short or stretched mid-cycle.

---
 rtl/duty_button_ctrl.sv | 153 +++++++++++++++
 tb/tb_duty_button_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_button_ctrl.sv
// duty_button_ctrl
//   Upstream control for the PWM generator. Synchronises and debounces the
//   raw push button, turns each accepted press into one duty-cycle step
//   (DUTY_MIN .. DUTY_MAX in DUTY_STEP increments, wrapping back to
//   DUTY_MIN), and hands the new duty to the PWM only at a period boundary.
//
// Ports
//   CLK          system clock, all state on the rising edge
//   RST          asynchronous, active-high reset
//   btn_in       raw button pin, asynchronous to CLK
//   period_start one-cycle pulse from the PWM when its counter wraps to 0
//   duty         applied duty value for the PWM compare
//   duty_update  one-cycle pulse in the cycle after duty changes
//   btn_level    debounced button level
module duty_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int DUTY_MIN        = 20,
  parameter int DUTY_MAX        = 100,
  parameter int DUTY_STEP       = 10,
  parameter int DUTY_RESET      = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_in,
  input  logic       period_start,
  output logic [7:0] duty,
  output logic       duty_update,
  output logic       btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } deb_state_t;

  // Step with wrap: the sum is formed one bit wider so an overflow past
  // DUTY_MAX can never alias back into the legal range.
  function automatic logic [7:0] next_duty(input logic [7:0] cur);
    logic [8:0] sum;
    sum = {1'b0, cur} + 9'(DUTY_STEP);
    if (sum > 9'(DUTY_MAX)) return 8'(DUTY_MIN);
    return sum[7:0];
  endfunction

  logic             sync1, sync2;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n;
  logic             press;
  logic [7:0]       pending;

  // ---- stage 0: two-flop synchroniser
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // ---- stage 1: debounce FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_n;
      // Registered rising edge of the debounced level: one pulse per press,
      // no repeat while held.
      press     <= level_n & ~btn_level;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = btn_level;
    unique case (state)
      IDLE_LOW: begin
        if (sync2) begin
          state_n = QUAL_HIGH;
          cnt_n   = CNT_ONE;
        end
      end
      QUAL_HIGH: begin
        if (!sync2) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_DONE) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          level_n = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          state_n = QUAL_LOW;
          cnt_n   = CNT_ONE;
        end
      end
      QUAL_LOW: begin
        if (sync2) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_DONE) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // ---- stage 2: pending step and period-aligned apply
  // Apply reads pending before this edge's increment, so a press landing on
  // a period boundary is carried to the following boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending     <= 8'(DUTY_RESET);
      duty        <= 8'(DUTY_RESET);
      duty_update <= 1'b0;
    end else begin
      if (press) pending <= next_duty(pending);
      if (period_start && (pending != duty)) begin
        duty        <= pending;
        duty_update <= 1'b1;
      end else begin
        duty_update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_duty_button_ctrl.sv
module tb_duty_button_ctrl;

  localparam int D     = 4;
  localparam int DMIN  = 20;
  localparam int DMAX  = 100;
  localparam int DSTEP = 10;
  localparam int DRST  = 20;

  logic       CLK;
  logic       RST;
  logic       btn_in;
  logic       period_start;
  logic [7:0] duty;
  logic       duty_update;
  logic       btn_level;

  duty_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX),
    .DUTY_STEP(DSTEP),
    .DUTY_RESET(DRST)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .btn_in(btn_in),
    .period_start(period_start),
    .duty(duty),
    .duty_update(duty_update),
    .btn_level(btn_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: button seen two edges late, level flips after D+1
  // consecutive samples disagreeing with it, duty arithmetic in plain ints.
  int   m_hist1, m_hist2;
  int   m_run;
  int   m_level;
  int   m_press;
  int   m_pending;
  int   m_duty;
  int   m_upd;

  function automatic int step_val(input int v);
    return (v + DSTEP > DMAX) ? DMIN : v + DSTEP;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_hist1   <= 0;
      m_hist2   <= 0;
      m_run     <= 0;
      m_level   <= 0;
      m_press   <= 0;
      m_pending <= DRST;
      m_duty    <= DRST;
      m_upd     <= 0;
    end else begin
      m_hist1 <= int'(btn_in);
      m_hist2 <= m_hist1;
      if (period_start && m_pending != m_duty) begin
        m_duty <= m_pending;
        m_upd  <= 1;
      end else begin
        m_upd  <= 0;
      end
      if (m_press != 0) m_pending <= step_val(m_pending);
      if (m_hist2 != m_level) begin
        if (m_run == D) begin
          m_level <= m_hist2;
          m_run   <= 0;
          m_press <= m_hist2;
        end else begin
          m_run   <= m_run + 1;
          m_press <= 0;
        end
      end else begin
        m_run   <= 0;
        m_press <= 0;
      end
    end
  end

  int n_chk;
  int n_fail;
  int upd_seen;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // One clock: drive inputs now, let the rising edge take them, then compare
  // every output with the model on the falling edge.
  task automatic step(input logic b, input logic p);
    btn_in       = b;
    period_start = p;
    @(negedge CLK);
    chk("duty", int'(duty), m_duty);
    chk("duty_update", int'(duty_update), m_upd);
    chk("btn_level", int'(btn_level), m_level);
    if (duty_update) upd_seen++;
  endtask

  task automatic press_btn(input int hold);
    repeat (hold) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
  endtask

  task automatic apply_period();
    step(btn_in, 1'b1);
    step(btn_in, 1'b0);
    step(btn_in, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    #2 RST = 1'b1;
    #1;
    chk({nm, "_rst_duty"}, int'(duty), DRST);
    chk({nm, "_rst_upd"}, int'(duty_update), 0);
    chk({nm, "_rst_level"}, int'(btn_level), 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int exp9 [9] = '{30, 40, 50, 60, 70, 80, 90, 100, 20};
  int n;

  initial begin
    n_chk = 0; n_fail = 0; upd_seen = 0;
    RST = 1'b1; btn_in = 1'b0; period_start = 1'b0;
    #1;
    chk("por_duty", int'(duty), DRST);
    chk("por_upd", int'(duty_update), 0);
    chk("por_level", int'(btn_level), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Idle with regular periods: nothing may move.
    for (int i = 0; i < 303; i++) step(1'b0, (i % 101) == 100);
    chk("idle_duty", int'(duty), 20);
    chk("idle_upd_count", upd_seen, 0);

    // Clean press: level rises D+3 edges after btn_in changes (D+1 after sync2).
    n = 0;
    do begin
      step(1'b1, 1'b0);
      n++;
    end while (!btn_level && n < 50);
    chk("latency_edges", n, D + 3);
    repeat (20 - n) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("press_not_yet_applied", int'(duty), 20);
    upd_seen = 0;
    apply_period();
    chk("press_applied", int'(duty), 30);
    chk("press_upd_count", upd_seen, 1);

    // Bounce then settle: exactly one step.
    do_reset("bounce");
    upd_seen = 0;
    step(1'b1, 1'b0); repeat (2) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0); repeat (2) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0); step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0); repeat (2) step(1'b0, 1'b0);
    chk("bounce_level_low", int'(btn_level), 0);
    repeat (20) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    apply_period();
    chk("bounce_duty", int'(duty), 30);
    chk("bounce_upd_count", upd_seen, 1);

    // Nine presses, each applied, wrapping 100 -> 20.
    do_reset("seq");
    for (int k = 0; k < 9; k++) begin
      press_btn(10);
      apply_period();
      chk($sformatf("seq_duty_%0d", k), int'(duty), exp9[k]);
    end

    // Three presses in one period collapse into one apply.
    do_reset("accum");
    upd_seen = 0;
    repeat (3) press_btn(10);
    apply_period();
    chk("accum_duty", int'(duty), 50);
    chk("accum_upd_count", upd_seen, 1);

    // Press event coincident with period_start.
    do_reset("coinc");
    press_btn(10);
    n = 0;
    do begin
      step(1'b1, 1'b0);
      n++;
    end while (!btn_level && n < 50);
    chk("coinc_level_reached", int'(btn_level), 1);
    step(1'b1, 1'b1);
    chk("coinc_old_pending", int'(duty), 30);
    repeat (12) step(1'b0, 1'b0);
    apply_period();
    chk("coinc_new_pending", int'(duty), 40);

    // Reset with a pending but unapplied step: step is lost.
    do_reset("lost");
    press_btn(10);
    apply_period();
    press_btn(10);
    chk("lost_pre_duty", int'(duty), 30);
    do_reset("lost");
    upd_seen = 0;
    apply_period();
    chk("lost_duty", int'(duty), 20);
    chk("lost_upd_count", upd_seen, 0);

    // Reset during qualification with the button held through release.
    repeat (4) step(1'b1, 1'b0);
    do_reset("qual");
    repeat (20) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    upd_seen = 0;
    apply_period();
    chk("held_duty", int'(duty), 30);
    chk("held_upd_count", upd_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
